// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time against a word-wide
// memory port. Handles alignment/range errors, sub-word load extraction with
// sign/zero extension, and read-modify-write for byte/half stores.
module lsu_ctrl #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic        err_q;
  // Holds the store data from accept, replaced by the merged word for sub-word stores.
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] lane_data;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [31:0] word_idx;

  assign accept   = req_valid && (state_q == IDLE);
  assign word_idx = {2'b00, addr_q[31:2]};

  // Decode alignment, size and range errors for the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_DEPTH) req_err = 1'b1;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  // Halfwords are aligned, so the byte-lane shift also covers the half lane.
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_data = mem_rdata >> lane_sh;
    load_ext  = mem_rdata;
    merged    = word_q;
    case (size_q)
      2'b00: begin
        load_ext = uns_q ? {24'h000000, lane_data[7:0]}
                         : {{24{lane_data[7]}}, lane_data[7:0]};
        merged   = (mem_rdata & ~(32'h0000_00FF << lane_sh))
                 | ({24'h000000, word_q[7:0]} << lane_sh);
      end
      2'b01: begin
        load_ext = uns_q ? {16'h0000, lane_data[15:0]}
                         : {{16{lane_data[15]}}, lane_data[15:0]};
        merged   = (mem_rdata & ~(32'h0000_FFFF << lane_sh))
                 | ({16'h0000, word_q[15:0]} << lane_sh);
      end
      default: begin
        load_ext = mem_rdata;
        merged   = word_q;
      end
    endcase
  end

  // Next-state and output decode; memory enables come straight from state.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          word_d  = req_wdata;
          rdata_d = '0;
          if (req_err)                           state_d = RESP;
          else if (!req_we || req_size != 2'b10) state_d = READ;
          else                                   state_d = WRITE;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = word_idx;
        if (we_q) begin
          word_d  = merged;
          state_d = WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = word_idx;
        mem_wdata = word_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;

  // State and request registers; request fields latched on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q   <= req_we;
        size_q <= req_size;
        uns_q  <= req_unsigned;
        addr_q <= req_addr;
        err_q  <= req_err;
      end
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller that sits between the pipeline's memory stage and the word-addressed data memory, acting as the initiator on the memory's `rd_en`/`wr_en`/`addr`/`wr_data`/`rdata` interface. It accepts one byte, halfword or word load/store request at a time. For each request it:
- checks alignment and range,
- drives the memory's single 32-bit word port,
- extracts and extends sub-word load data,
- performs a read-modify-write for sub-word stores, because the memory has no byte enables.

## Interface

Parameters:
- `MEM_DEPTH`, 1024: number of 32-bit words in the data memory; word index ≥ `MEM_DEPTH` is out of range.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified for byte/half.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal size or out of range; valid with `resp_valid`.
- `mem_rd_en`  out  1  memory read enable.
- `mem_wr_en`  out  1  memory write enable.
- `mem_addr`  out  32  word index (`req_addr >> 2`).
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  combinational read data from memory.

## Operation

- **States.** IDLE, READ, WRITE, RESP.
- **IDLE.**
  - `req_ready` = 1.
  - On `req_valid & req_ready` at a posedge, latch all request fields.
  - Error check:
    - half needs `addr[0]` = 0;
    - word needs `addr[1:0]` = 0;
    - `req_size` = 11 is illegal;
    - `addr[31:2]` ≥ `MEM_DEPTH` is out of range.
  - Next state:
    - error → RESP with `err` = 1;
    - load → READ;
    - word store → WRITE;
    - byte/half store → READ.
- **READ.**
  - `mem_rd_en` = 1, `mem_addr` = word index.
  - At the closing posedge, capture `mem_rdata`.
  - Load:
    - byte lane `addr[1:0]` selects bits `[8*lane+7 : 8*lane]`;
    - half lane `addr[1]` selects bits `[16*addr[1]+15 : 16*addr[1]]`;
    - extend per `req_unsigned`;
    - go to RESP.
  - Sub-word store: merge `req_wdata[7:0]` (byte) or `req_wdata[15:0]` (half) into the captured word at the same lane, then go to WRITE.
- **WRITE.**
  - `mem_wr_en` = 1, `mem_addr` = word index.
  - `mem_wdata` = `req_wdata` (word store) or the merged word (sub-word store).
  - Held stable for the whole cycle; the memory commits at that cycle's negedge.
  - Next state: RESP.
- **RESP.**
  - `resp_valid` = 1 for exactly one cycle with `resp_rdata`/`resp_err`, then IDLE.
  - No response backpressure.
- **Idle outputs.** Outside READ/WRITE: `mem_rd_en` = `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Mutual exclusion.** `mem_rd_en` and `mem_wr_en` are never asserted together.
- **Error requests.** No memory access of any kind.
- **Ordering.** One outstanding request; a load following a store to the same word returns the stored data.

## Timing

- **Reset values (`rst_n` low).**
  - State = IDLE; `req_ready` = 1.
  - `resp_valid`, `resp_err`, `mem_rd_en`, `mem_wr_en` = 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- **Memory enables.** Decoded from state, so an asynchronous reset removes `mem_wr_en` immediately. A reset mid-WRITE before the negedge leaves memory unchanged, and the in-flight request is dropped with no response.
- **Latency**, counted in cycles after the accept edge, to the cycle in which `resp_valid` is high:

| Request | Cycle of `resp_valid` |
|---|---|
| Error | 1st |
| Load (any size) | 2nd |
| Word store | 2nd |
| Byte/half store | 3rd |

- **`req_ready`.** Low in READ, WRITE and RESP.
- **Throughput.**
  - Back-to-back loads or word stores: one accepted every 3 cycles.
  - Sub-word stores: one every 4 cycles.
- **`resp_rdata`.** Registered; stable only while `resp_valid` = 1.

## Test plan

- **Word store then load.** Word store `0xDEADBEEF` @ `0x10`, then word load @ `0x10`.
  - Store: `mem_wr_en` high one cycle with `mem_addr` = 4; `resp_valid` in the 2nd cycle after accept.
  - Load: `resp_rdata` = `0xDEADBEEF`, `resp_err` = 0.
- **Byte store and loads.** Preload word `0x11223344` @ `0x200`; byte store `0xAB` @ `0x203`.
  - Store: READ then WRITE, memory word becomes `0xAB223344`, response in the 3rd cycle.
  - Signed byte load @ `0x203` → `0xFFFFFFAB`; unsigned → `0x000000AB`.
- **Half loads.** Word `0x80017FFF` @ `0x20`.
  - Signed half load @ `0x22` → `0xFFFF8001`.
  - Signed half load @ `0x20` → `0x00007FFF`.
  - Unsigned half load @ `0x22` → `0x00008001`.
- **Error requests.** Each of: word load @ `0x06`, half store @ `0x21`, `req_size` = 11, word load @ `0x1000` (index 1024).
  - `resp_err` = 1 and `resp_rdata` = 0 in the 1st cycle after accept.
  - `mem_rd_en`/`mem_wr_en` never asserted.
- **Reset mid-store.** Assert `rst_n` low mid-WRITE (before the negedge) of a half store `0xBEEF` @ `0x200` over `0x11223344`.
  - `mem_wr_en` drops immediately; memory still reads `0x11223344`.
  - No `resp_valid`; `req_ready` = 1.
- **Back-to-back loads.** `req_valid` held high for three word loads @ `0x0`, `0x4`, `0x8`.
  - Accepts spaced exactly 3 cycles apart; `req_ready` low in between.
  - Three `resp_valid` pulses, in order, with the correct data.
